// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by an in-order prefetch FIFO, with a bypass path
// straight from fetch into the IR when the queue is empty.
module ir_prefetch_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_in,
  input  logic                       fetch_valid_in,
  input  logic [WIDTH-1:0]           fetch_ins_in,
  output logic                       fetch_ready_out,
  input  logic                       il_in,
  output logic [WIDTH-1:0]           ins_out,
  output logic                       ir_valid_out,
  output logic                       stall_out,
  output logic [WIDTH-1:0]           ia_out,
  output logic [WIDTH-1:0]           iv_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;

  logic empty;
  logic push;
  logic bypass;
  logic wr_en;
  logic rd_en;

  assign empty           = (count_q == '0);
  assign fetch_ready_out = (count_q < CntFull) && !flush_in;
  assign push            = fetch_valid_in && fetch_ready_out;
  // An empty queue hands the fetched word straight to the IR instead of storing it.
  assign bypass          = il_in && !flush_in && empty && push;
  assign wr_en           = push && !bypass;
  assign rd_en           = il_in && !flush_in && !empty;
  assign stall_out       = il_in && empty && !push && !flush_in;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = fetch_ins_in;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (il_in && !flush_in) begin
      if (!empty) begin
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end else if (push) begin
        ir_d       = fetch_ins_in;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end

    // Flush wins over everything; IR contents are kept, only validity drops.
    if (flush_in) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ins_out      = ir_q;
  assign ir_valid_out = ir_valid_q;
  assign count_out    = count_q;
  assign ia_out       = {{(WIDTH-6){ir_q[8]}}, ir_q[8:6], ir_q[2:0]};
  assign iv_out       = {{(WIDTH-3){1'b0}}, ir_q[2:0]};

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed bench for ir_prefetch_queue: FIFO order, full refusal, wrap, bypass,
// stall, flush priority and asynchronous reset.
module tb_ir_prefetch_queue;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             flush_in;
  logic             fetch_valid_in;
  logic [WIDTH-1:0] fetch_ins_in;
  logic             fetch_ready_out;
  logic             il_in;
  logic [WIDTH-1:0] ins_out;
  logic             ir_valid_out;
  logic             stall_out;
  logic [WIDTH-1:0] ia_out;
  logic [WIDTH-1:0] iv_out;
  logic [2:0]       count_out;

  int errors = 0;
  int checks = 0;

  ir_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_in       (flush_in),
    .fetch_valid_in (fetch_valid_in),
    .fetch_ins_in   (fetch_ins_in),
    .fetch_ready_out(fetch_ready_out),
    .il_in          (il_in),
    .ins_out        (ins_out),
    .ir_valid_out   (ir_valid_out),
    .stall_out      (stall_out),
    .ia_out         (ia_out),
    .iv_out         (iv_out),
    .count_out      (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_in       = 1'b0;
    fetch_valid_in = 1'b0;
    fetch_ins_in   = '0;
    il_in          = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    checks++;
    if (ins_out !== 16'h0000 || ir_valid_out !== 1'b0 || count_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: ins=%h valid=%b count=%0d, want 0000/0/0",
               ins_out, ir_valid_out, count_out);
    end
    checks++;
    if (fetch_ready_out !== 1'b1 || stall_out !== 1'b0 || ia_out !== 16'h0000 ||
        iv_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_derived: ready=%b stall=%b ia=%h iv=%h, want 1/0/0000/0000",
               fetch_ready_out, stall_out, ia_out, iv_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_full();
    logic [WIDTH-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      fetch_valid_in = 1'b1;
      fetch_ins_in   = words[i];
      cyc();
    end
    fetch_ins_in = 16'h5555;
    #1;
    checks++;
    if (count_out !== 3'd4 || fetch_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d ready=%b, want 4/0", count_out, fetch_ready_out);
    end
    cyc();
    checks++;
    if (count_out !== 3'd4) begin
      errors++;
      $display("FAIL refused_push: count=%0d, want 4", count_out);
    end
    idle();
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    il_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (ins_out !== words[i] || ir_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: ins=%h valid=%b, want %h/1", i, ins_out, ir_valid_out,
                 words[i]);
      end
    end
    checks++;
    if (count_out !== 3'd0) begin
      errors++;
      $display("FAIL drain_count: count=%0d, want 0", count_out);
    end
    idle();
    cyc();
  endtask

  // Eight words through the queue with overlapping push/pop, so both pointers wrap again.
  task automatic test_wrap();
    logic [WIDTH-1:0] next_in;
    logic [WIDTH-1:0] next_out;
    next_in  = 16'hA000;
    next_out = 16'hA000;
    fetch_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_ins_in = next_in;
      next_in++;
      cyc();
    end
    il_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_ins_in = next_in;
      next_in++;
      cyc();
      checks++;
      if (ins_out !== next_out || count_out !== 3'd2) begin
        errors++;
        $display("FAIL wrap_pp_%0d: ins=%h count=%0d, want %h/2", i, ins_out, count_out,
                 next_out);
      end
      next_out++;
    end
    fetch_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (ins_out !== next_out) begin
        errors++;
        $display("FAIL wrap_tail_%0d: ins=%h, want %h", i, ins_out, next_out);
      end
      next_out++;
    end
    checks++;
    if (count_out !== 3'd0) begin
      errors++;
      $display("FAIL wrap_count: count=%0d, want 0", count_out);
    end
    idle();
    cyc();
  endtask

  task automatic test_bypass();
    il_in          = 1'b1;
    fetch_valid_in = 1'b1;
    fetch_ins_in   = 16'h01C5;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL bypass_stall: stall=%b, want 0", stall_out);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (ins_out !== 16'h01C5 || ir_valid_out !== 1'b1 || count_out !== 3'd0) begin
      errors++;
      $display("FAIL bypass_ir: ins=%h valid=%b count=%0d, want 01c5/1/0",
               ins_out, ir_valid_out, count_out);
    end
    checks++;
    if (ia_out !== 16'hFFFD || iv_out !== 16'h0005) begin
      errors++;
      $display("FAIL bypass_imm: ia=%h iv=%h, want fffd/0005", ia_out, iv_out);
    end
  endtask

  task automatic test_stall();
    il_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_flag: stall=%b, want 1", stall_out);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (ir_valid_out !== 1'b0 || ins_out !== 16'h01C5) begin
      errors++;
      $display("FAIL stall_ir: valid=%b ins=%h, want 0/01c5", ir_valid_out, ins_out);
    end
  endtask

  task automatic test_flush();
    fetch_valid_in = 1'b1;
    fetch_ins_in   = 16'hB001;
    cyc();
    fetch_ins_in   = 16'hB002;
    cyc();
    flush_in       = 1'b1;
    il_in          = 1'b1;
    fetch_ins_in   = 16'hB003;
    #1;
    checks++;
    if (fetch_ready_out !== 1'b0 || stall_out !== 1'b0 || count_out !== 3'd2) begin
      errors++;
      $display("FAIL flush_comb: ready=%b stall=%b count=%0d, want 0/0/2",
               fetch_ready_out, stall_out, count_out);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (count_out !== 3'd0 || ir_valid_out !== 1'b0 || ins_out !== 16'h01C5) begin
      errors++;
      $display("FAIL flush_state: count=%0d valid=%b ins=%h, want 0/0/01c5",
               count_out, ir_valid_out, ins_out);
    end
    // The word offered during flush must not appear: the queue is empty, so il stalls.
    il_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_lost: stall=%b, want 1", stall_out);
    end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_reset_midstream();
    fetch_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_ins_in = 16'hC001 + 16'(i);
      cyc();
    end
    fetch_valid_in = 1'b0;
    il_in          = 1'b1;
    cyc();
    idle();
    #1;
    checks++;
    if (count_out !== 3'd3 || ins_out !== 16'hC001) begin
      errors++;
      $display("FAIL pre_reset: count=%0d ins=%h, want 3/c001", count_out, ins_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count_out !== 3'd0 || ins_out !== 16'h0000 || ir_valid_out !== 1'b0 ||
        ia_out !== 16'h0000 || iv_out !== 16'h0000 || fetch_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: count=%0d ins=%h valid=%b ia=%h iv=%h ready=%b",
               count_out, ins_out, ir_valid_out, ia_out, iv_out, fetch_ready_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_drain();
    test_wrap();
    test_bypass();
    test_stall();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
